// File: rtl/stage2_decode_pkg.sv
// Shared constants, opcode encoding and decoded-instruction record for the decode stage.
// Field positions follow the fixed 4/4/4/4/16 instruction layout.
package stage2_decode_pkg;

  localparam int PC_W       = 30;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 4;
  localparam int OP_W       = 4;

  localparam int OP_LSB  = 28;
  localparam int RD_LSB  = 24;
  localparam int RA_LSB  = 20;
  localparam int RB_LSB  = 16;
  localparam int IMM_W   = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 4'd0,
    OP_ALU    = 4'd1,
    OP_ALUI   = 4'd2,
    OP_LOAD   = 4'd3,
    OP_STORE  = 4'd4,
    OP_BRANCH = 4'd5,
    OP_JAL    = 4'd6,
    OP_LUI    = 4'd7
  } opcode_e;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] ra;
    logic [REG_ADDR_W-1:0] rb;
    logic [XLEN-1:0]       imm;
    logic [PC_W-1:0]       pc;
    logic [PC_W-1:0]       target;
    logic                  illegal;
  } dec_t;

  function automatic logic uses_ra(input logic [OP_W-1:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic logic uses_rb(input logic [OP_W-1:0] op);
    return (op == OP_ALU) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/stage2_decode_if.sv
// Fetch/execute-facing bus of the decode stage: instruction in, decoded fields out.
interface stage2_decode_if;
  import stage2_decode_pkg::*;

  logic [XLEN-1:0]       ir_i;
  logic [PC_W-1:0]       pc_i;
  logic                  valid_i;
  logic                  stall_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  valid_o;
  logic [OP_W-1:0]       op_o;
  logic [REG_ADDR_W-1:0] rd_o;
  logic [REG_ADDR_W-1:0] ra_o;
  logic [REG_ADDR_W-1:0] rb_o;
  logic [XLEN-1:0]       imm_o;
  logic [PC_W-1:0]       pc_o;
  logic [PC_W-1:0]       target_o;
  logic                  illegal_o;

  modport slave (
    input  ir_i, pc_i, valid_i, stall_i, flush_i,
    output stall_o, valid_o, op_o, rd_o, ra_o, rb_o, imm_o, pc_o, target_o, illegal_o
  );

  modport master (
    output ir_i, pc_i, valid_i, stall_i, flush_i,
    input  stall_o, valid_o, op_o, rd_o, ra_o, rb_o, imm_o, pc_o, target_o, illegal_o
  );
endinterface

// File: rtl/stage2_decode_hold_buf.sv
// One-entry holding register for an instruction that arrived while decode could not advance.
// Clear wins over load; a full buffer is never overwritten.
module decode_hold_buf
  import stage2_decode_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] ir_d_i,
  input  logic [PC_W-1:0] pc_d_i,
  output logic            full_o,
  output logic [XLEN-1:0] ir_o,
  output logic [PC_W-1:0] pc_o
);

  logic            full_q;
  logic [XLEN-1:0] ir_q;
  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
      ir_q   <= '0;
      pc_q   <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i && !full_q) begin
      full_q <= 1'b1;
      ir_q   <= ir_d_i;
      pc_q   <= pc_d_i;
    end
  end

  assign full_o = full_q;
  assign ir_o   = ir_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/stage2_decode.sv
// Decode stage: field extraction, branch target, load-use bubble and stall back to fetch.
// Build option: define STAGE2_ILLEGAL_OP_EN to flag opcodes 8-15 as illegal instead of NOP.
module stage2_decode
  import stage2_decode_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_n_i,
  stage2_decode_if.slave bus
);

  logic            hold_full, hold_load, hold_clear;
  logic [XLEN-1:0] hold_ir, src_ir;
  logic [PC_W-1:0] hold_pc, src_pc;
  logic            src_valid;
  logic            hazard, upd_en, bubble;
  logic [OP_W-1:0] raw_op;
  logic [XLEN-1:0] imm_sext;
  dec_t            dec_d, dec_q;
  logic            valid_q;

  decode_hold_buf u_hold (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .ir_d_i  (bus.ir_i),
    .pc_d_i  (bus.pc_i),
    .full_o  (hold_full),
    .ir_o    (hold_ir),
    .pc_o    (hold_pc)
  );

  // A held instruction always takes precedence over whatever fetch is presenting.
  assign src_ir    = hold_full ? hold_ir : bus.ir_i;
  assign src_pc    = hold_full ? hold_pc : bus.pc_i;
  assign src_valid = hold_full | bus.valid_i;

  assign raw_op   = src_ir[OP_LSB +: OP_W];
  assign imm_sext = {{(XLEN-IMM_W){src_ir[IMM_W-1]}}, src_ir[IMM_W-1:0]};

  always_comb begin
    dec_d        = '0;
    dec_d.rd     = src_ir[RD_LSB +: REG_ADDR_W];
    dec_d.ra     = src_ir[RA_LSB +: REG_ADDR_W];
    dec_d.rb     = src_ir[RB_LSB +: REG_ADDR_W];
    dec_d.pc     = src_pc;
    dec_d.target = src_pc + {{(PC_W-1){1'b0}}, 1'b1} + imm_sext[PC_W-1:0];
    dec_d.imm    = (raw_op == OP_LUI) ? {src_ir[IMM_W-1:0], {(XLEN-IMM_W){1'b0}}} : imm_sext;
`ifdef STAGE2_ILLEGAL_OP_EN
    dec_d.op      = raw_op;
    dec_d.illegal = raw_op[OP_W-1];
`else
    dec_d.op      = raw_op[OP_W-1] ? OP_NOP : raw_op;
    dec_d.illegal = 1'b0;
`endif
  end

  // Load-use: the instruction in the output register is a load whose result src needs.
  assign hazard = valid_q && (dec_q.op == OP_LOAD) && (dec_q.rd != '0) &&
                  ((uses_ra(raw_op) && (dec_d.ra == dec_q.rd)) ||
                   (uses_rb(raw_op) && (dec_d.rb == dec_q.rd)));

  assign bus.stall_o = !bus.flush_i && (bus.stall_i || (src_valid && hazard));

  always_comb begin
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    upd_en     = 1'b0;
    bubble     = 1'b0;
    if (bus.flush_i) begin
      hold_clear = 1'b1;
    end else if (bus.stall_i) begin
      hold_load = bus.valid_i && !hold_full;
    end else if (src_valid && hazard) begin
      bubble    = 1'b1;
      hold_load = !hold_full;
    end else begin
      upd_en     = 1'b1;
      hold_clear = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (bus.flush_i || bubble) begin
      valid_q <= 1'b0;
    end else if (upd_en) begin
      valid_q <= src_valid;
      dec_q   <= dec_d;
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.op_o      = dec_q.op;
  assign bus.rd_o      = dec_q.rd;
  assign bus.ra_o      = dec_q.ra;
  assign bus.rb_o      = dec_q.rb;
  assign bus.imm_o     = dec_q.imm;
  assign bus.pc_o      = dec_q.pc;
  assign bus.target_o  = dec_q.target;
  assign bus.illegal_o = dec_q.illegal;

  // While an instruction is held, fetch may only re-present that same PC.
  hold_pc_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (hold_full && bus.valid_i && !bus.flush_i) |-> (bus.pc_i == hold_pc));

endmodule
